wave_synth_low: RTL and testbench

//  Test-tone generator: the transmit-side counterpart of the low-band wave analyzer.

---
 rtl/wave_synth_low.sv | 175 +++++++++++++++++
 tb/tb_wave_synth_low.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/wave_synth_low.sv
// Test-tone generator centred on MID: square wave by default, triangle when TRIANGLE_EN is defined
// and wave_sel=1 (serial divider precomputes per-phase slopes). One registered sample per smp_en strobe.
module wave_synth_low #(
  parameter int DATA_W = 16,
  parameter int PER_W  = 22,
  parameter int AMP_W  = 12,
  parameter int MID    = 567
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              start,
  input  logic              stop,
  input  logic              smp_en,
  input  logic [PER_W-1:0]  period,
  input  logic [AMP_W-1:0]  amp,
  input  logic [7:0]        n_cyc,
  input  logic              wave_sel,
  output logic              busy,
  output logic              smp_vld,
  output logic              cyc_done,
  output logic [DATA_W-1:0] lft_out,
  output logic [DATA_W-1:0] rght_out
);
  typedef enum logic [1:0] {IDLE, LOAD, PH_A, PH_B} state_t;
  localparam logic [DATA_W-1:0] MID_V = DATA_W'(MID);

  state_t            state_q, state_d;
  logic [PER_W-1:0]  per_q, per_d, idx_q, idx_d;
  logic [AMP_W-1:0]  amp_q, amp_d;
  logic [7:0]        ncyc_q, ncyc_d, pcnt_q, pcnt_d;
  logic              stop_pend_q, stop_pend_d, vld_q, vld_d, done_q, done_d;
  logic [DATA_W-1:0] lft_q, lft_d;

  logic [PER_W-1:0]  per_clamp, hf, hr, h_cur;
  logic [AMP_W:0]    amp_up;
  logic [DATA_W-1:0] hi, lo, sq_val, smp_val;
  logic              in_a, ph_last, load_done, sample_go, run_end;

  assign per_clamp = (period < PER_W'(2)) ? PER_W'(2) : period;
  assign hf        = per_q >> 1;
  assign hr        = per_q - hf;
  assign in_a      = (state_q != PH_B);
  assign h_cur     = in_a ? hf : hr;
  assign ph_last   = (idx_q == h_cur - PER_W'(1));
  assign amp_up    = {1'b0, amp_q} + (AMP_W+1)'(1);
  assign hi        = MID_V + DATA_W'(amp_up[AMP_W:1]);
  assign lo        = MID_V - DATA_W'(amp_q[AMP_W-1:1]);
  assign sq_val    = in_a ? hi : lo;
  assign run_end   = ((ncyc_q != 8'd0) && (pcnt_q + 8'd1 == ncyc_q)) || stop_pend_q || stop;
  assign sample_go = smp_en && (state_q == PH_A || state_q == PH_B || load_done);

`ifdef TRIANGLE_EN
  localparam int CNT_W = $clog2(2*AMP_W);
  localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(AMP_W-1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(2*AMP_W-1);

  logic              tri_q, tri_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AMP_W-1:0]  dvd_q, dvd_d, qa_q, qa_d, qb_q, qb_d, div_quo;
  logic [PER_W-1:0]  rem_q, rem_d, ra_q, ra_d, rb_q, rb_d, acc_q, acc_d;
  logic [PER_W-1:0]  div_den, div_sh, div_rem, acc_next;
  logic [PER_W:0]    acc_sum, acc_sub;
  logic              div_bit, carry;
  logic [DATA_W-1:0] tri_val;

  assign load_done = (state_q == LOAD) && (cnt_q == CNT_END);
  assign smp_val   = tri_q ? tri_val : sq_val;

  // Restoring division: dividend shifts out of dvd_q while quotient bits shift in.
  always_comb begin
    div_den  = (cnt_q <= CNT_MID) ? hf : hr;
    div_sh   = {rem_q[PER_W-2:0], dvd_q[AMP_W-1]};
    div_bit  = (div_sh >= div_den);
    div_rem  = div_bit ? div_sh - div_den : div_sh;
    div_quo  = {dvd_q[AMP_W-2:0], div_bit};
    acc_sum  = {1'b0, acc_q} + {1'b0, (in_a ? ra_q : rb_q)};
    acc_sub  = acc_sum - {1'b0, h_cur};
    carry    = (acc_sum >= {1'b0, h_cur});
    acc_next = carry ? acc_sub[PER_W-1:0] : acc_sum[PER_W-1:0];
    if (idx_q == '0)  tri_val = in_a ? hi : lo;
    else if (in_a)    tri_val = lft_q - DATA_W'(qa_q) - DATA_W'(carry);
    else              tri_val = lft_q + DATA_W'(qb_q) + DATA_W'(carry);
  end

  always_comb begin
    tri_d = tri_q; cnt_d = cnt_q; dvd_d = dvd_q; rem_d = rem_q;
    qa_d = qa_q; qb_d = qb_q; ra_d = ra_q; rb_d = rb_q; acc_d = acc_q;
    if (state_q == IDLE) begin
      tri_d = wave_sel; cnt_d = '0; dvd_d = amp; rem_d = '0;
    end else if (state_q == LOAD) begin
      cnt_d = cnt_q + CNT_W'(1); dvd_d = div_quo; rem_d = div_rem;
      if (cnt_q == CNT_MID) begin
        qa_d = div_quo; ra_d = div_rem; dvd_d = amp_q; rem_d = '0;
      end
      if (cnt_q == CNT_END) begin
        qb_d = div_quo; rb_d = div_rem;
      end
    end
    if (sample_go) acc_d = (idx_q == '0) ? '0 : acc_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tri_q <= 1'b0; cnt_q <= '0; dvd_q <= '0; rem_q <= '0;
      qa_q <= '0; qb_q <= '0; ra_q <= '0; rb_q <= '0; acc_q <= '0;
    end else begin
      tri_q <= tri_d; cnt_q <= cnt_d; dvd_q <= dvd_d; rem_q <= rem_d;
      qa_q <= qa_d; qb_q <= qb_d; ra_q <= ra_d; rb_q <= rb_d; acc_q <= acc_d;
    end
  end
`else
  logic unused_wave_sel;
  assign unused_wave_sel = wave_sel;
  assign load_done = 1'b0;
  assign smp_val   = sq_val;
`endif

  always_comb begin
    state_d = state_q; per_d = per_q; amp_d = amp_q; ncyc_d = ncyc_q;
    pcnt_d = pcnt_q; idx_d = idx_q; stop_pend_d = stop_pend_q;
    vld_d = 1'b0; done_d = 1'b0; lft_d = lft_q;
    case (state_q)
      IDLE: begin
        lft_d = MID_V;
        stop_pend_d = 1'b0;
        if (start) begin
          per_d = per_clamp; amp_d = amp; ncyc_d = n_cyc; pcnt_d = '0; idx_d = '0;
          state_d = PH_A;
`ifdef TRIANGLE_EN
          if (wave_sel) state_d = LOAD;
`endif
        end
      end
      LOAD: if (load_done) state_d = PH_A;
      default: ;
    endcase
    if (stop && state_q != IDLE) stop_pend_d = 1'b1;
    // The final LOAD cycle doubles as the first phase-A sample slot.
    if (sample_go) begin
      lft_d = smp_val;
      vld_d = 1'b1;
      idx_d = idx_q + PER_W'(1);
      if (ph_last) begin
        idx_d = '0;
        if (in_a) begin
          state_d = PH_B;
        end else begin
          done_d = 1'b1;
          pcnt_d = pcnt_q + 8'd1;
          state_d = run_end ? IDLE : PH_A;
        end
      end
    end
    if (clr) begin
      state_d = IDLE; vld_d = 1'b0; done_d = 1'b0; lft_d = MID_V; stop_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE; per_q <= '0; amp_q <= '0; ncyc_q <= '0; pcnt_q <= '0;
      idx_q <= '0; stop_pend_q <= 1'b0; vld_q <= 1'b0; done_q <= 1'b0; lft_q <= MID_V;
    end else begin
      state_q <= state_d; per_q <= per_d; amp_q <= amp_d; ncyc_q <= ncyc_d; pcnt_q <= pcnt_d;
      idx_q <= idx_d; stop_pend_q <= stop_pend_d; vld_q <= vld_d; done_q <= done_d; lft_q <= lft_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign smp_vld  = vld_q;
  assign cyc_done = done_q;
  assign lft_out  = lft_q;
  assign rght_out = lft_q;
endmodule

// File: tb/tb_wave_synth_low.sv
// Directed bench for wave_synth_low: vector table of complete runs plus hand-written
// sequences for stop, clr, sparse sample strobes and (with TRIANGLE_EN) the triangle path.
module tb_wave_synth_low;
  logic        clk = 1'b0;
  logic        rst_n, clr, start, stop, smp_en, wave_sel;
  logic [21:0] period;
  logic [11:0] amp;
  logic [7:0]  n_cyc;
  logic        busy, smp_vld, cyc_done;
  logic [15:0] lft_out, rght_out;

  int n_chk = 0;
  int n_fail = 0;

  wave_synth_low dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .stop(stop), .smp_en(smp_en),
    .period(period), .amp(amp), .n_cyc(n_cyc), .wave_sel(wave_sel),
    .busy(busy), .smp_vld(smp_vld), .cyc_done(cyc_done),
    .lft_out(lft_out), .rght_out(rght_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [21:0]          per;
    logic [11:0]          amp;
    logic [7:0]           ncyc;
    int                   n;
    logic [0:9][15:0]     smp;
    logic [0:9]           dmask;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [21:0] p, input logic [11:0] a, input logic [7:0] nc);
    period = p; amp = a; n_cyc = nc; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Free-running square run stopped by a one-cycle pulse landing on sample stop_at+1.
  task automatic run_stop(input logic [21:0] p, input int stop_at, input int exp_cnt, input string nm);
    int cnt = 0;
    logic last_done = 1'b0;
    smp_en = 1'b1;
    accept(p, 12'd100, 8'd0);
    for (int i = 0; i < 80 && busy; i++) begin
      tick();
      if (smp_vld) begin cnt++; last_done = cyc_done; end
      stop = smp_vld && (cnt == stop_at);
    end
    stop = 1'b0;
    chk({nm, "_count"}, cnt, exp_cnt);
    chk({nm, "_last_done"}, last_done, 1);
    chk({nm, "_busy"}, busy, 0);
    tick();
  endtask

  initial begin
    logic [15:0] exp_lft;
    int          nstrobe;
    logic [15:0] sparse_seq [4];

    vecs[0] = '{per: 22'd4, amp: 12'd100, ncyc: 8'd2, n: 8,
                smp: '{16'd617,16'd617,16'd517,16'd517,16'd617,16'd617,16'd517,16'd517,16'd0,16'd0},
                dmask: 10'b0001000100};
    vecs[1] = '{per: 22'd5, amp: 12'd101, ncyc: 8'd2, n: 10,
                smp: '{16'd618,16'd618,16'd517,16'd517,16'd517,16'd618,16'd618,16'd517,16'd517,16'd517},
                dmask: 10'b0000100001};
    vecs[2] = '{per: 22'd1, amp: 12'd10, ncyc: 8'd3, n: 6,
                smp: '{16'd572,16'd562,16'd572,16'd562,16'd572,16'd562,16'd0,16'd0,16'd0,16'd0},
                dmask: 10'b0101010000};
    vecs[3] = '{per: 22'd0, amp: 12'd0, ncyc: 8'd1, n: 2,
                smp: '{16'd567,16'd567,16'd0,16'd0,16'd0,16'd0,16'd0,16'd0,16'd0,16'd0},
                dmask: 10'b0100000000};
    vecs[4] = '{per: 22'd3, amp: 12'd7, ncyc: 8'd1, n: 3,
                smp: '{16'd571,16'd564,16'd564,16'd0,16'd0,16'd0,16'd0,16'd0,16'd0,16'd0},
                dmask: 10'b0010000000};
    sparse_seq = '{16'd617, 16'd517, 16'd617, 16'd517};

    rst_n = 1'b0; clr = 1'b0; start = 1'b0; stop = 1'b0; smp_en = 1'b0; wave_sel = 1'b0;
    period = '0; amp = '0; n_cyc = '0;
    #23;
    chk("reset_busy", busy, 0);
    chk("reset_vld", smp_vld, 0);
    chk("reset_done", cyc_done, 0);
    chk("reset_lft", lft_out, 567);
    chk("reset_rght", rght_out, 567);
    rst_n = 1'b1;
    tick();

    // Complete square runs from the table.
    smp_en = 1'b1;
    foreach (vecs[v]) begin
      accept(vecs[v].per, vecs[v].amp, vecs[v].ncyc);
      chk($sformatf("v%0d_busy_on_accept", v), busy, 1);
      chk($sformatf("v%0d_no_vld_on_accept", v), smp_vld, 0);
      for (int k = 0; k < vecs[v].n; k++) begin
        tick();
        chk($sformatf("v%0d_s%0d_vld", v, k), smp_vld, 1);
        chk($sformatf("v%0d_s%0d_lft", v, k), lft_out, vecs[v].smp[k]);
        chk($sformatf("v%0d_s%0d_rght", v, k), rght_out, vecs[v].smp[k]);
        chk($sformatf("v%0d_s%0d_done", v, k), cyc_done, vecs[v].dmask[k]);
      end
      chk($sformatf("v%0d_busy_end", v), busy, 0);
      tick();
      chk($sformatf("v%0d_idle_lft", v), lft_out, 567);
      chk($sformatf("v%0d_idle_vld", v), smp_vld, 0);
    end

    // stop mid-period completes that period; stop on the last sample ends right there.
    run_stop(22'd4, 9, 12, "stop_mid");
    run_stop(22'd2, 3, 4, "stop_last");

    // stop in IDLE is dropped: a later free run survives past its first period end.
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_idle_busy", busy, 0);
    accept(22'd4, 12'd100, 8'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("stop_idle_still_running", busy, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_lft", lft_out, 567);
    chk("clr_vld", smp_vld, 0);
    tick();

    // clr wins over start.
    clr = 1'b1; start = 1'b1;
    tick();
    clr = 1'b0; start = 1'b0;
    chk("clr_over_start_busy", busy, 0);
    tick();

    // Sparse strobes: one smp_en every 4th clock; a second start mid-run is ignored.
    smp_en = 1'b0;
    accept(22'd2, 12'd100, 8'd2);
    exp_lft = 16'd567;
    nstrobe = 0;
    for (int c = 0; c < 16; c++) begin
      smp_en = ((c % 4) == 3);
      if (c == 6) begin period = 22'd8; amp = 12'd50; n_cyc = 8'd5; start = 1'b1; end
      else start = 1'b0;
      tick();
      if (smp_en) begin exp_lft = sparse_seq[nstrobe]; nstrobe++; end
      chk($sformatf("sparse_c%0d_vld", c), smp_vld, smp_en);
      chk($sformatf("sparse_c%0d_lft", c), lft_out, exp_lft);
      chk($sformatf("sparse_c%0d_done", c), cyc_done, smp_en && (nstrobe % 2 == 0));
    end
    start = 1'b0; smp_en = 1'b0;
    chk("sparse_busy_end", busy, 0);
    tick();

`ifdef TRIANGLE_EN
    begin
      logic [15:0] tri_seq [8];
      int wait_cnt = 0;
      tri_seq = '{16'd571, 16'd569, 16'd567, 16'd565, 16'd563, 16'd565, 16'd567, 16'd569};
      smp_en = 1'b1; wave_sel = 1'b1;
      accept(22'd8, 12'd8, 8'd2);
      wave_sel = 1'b0;
      while (!smp_vld && wait_cnt < 100) begin
        if (busy) wait_cnt++;
        tick();
      end
      chk("tri_load_cycles", wait_cnt, 24);
      for (int k = 0; k < 16; k++) begin
        if (k > 0) tick();
        chk($sformatf("tri_s%0d_vld", k), smp_vld, 1);
        chk($sformatf("tri_s%0d_lft", k), lft_out, tri_seq[k % 8]);
        chk($sformatf("tri_s%0d_done", k), cyc_done, (k % 8) == 7);
      end
      chk("tri_busy_end", busy, 0);
      tick();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
